bounce_generator: RTL
=====================

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 The block SHALL have parameter BOUNCE_COUNT, default 7: number of chatter toggles per transition, legal range 1..255.
REQ-002 The block SHALL have parameter TOGGLE_INTERVAL, default 50: clock cycles between chatter toggles in fixed mode, legal range 1..65535.
REQ-003 The block SHALL have parameter SETTLE_CYCLES, default 200: clock cycles the final level is held before completion, legal range 1..65535.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value, used only in random mode.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port level_in, input, 1 bit: clean target level, synchronous to clk.
REQ-008 The block SHALL have port noisy, output, 1 bit, registered: emulated bouncing contact, the stimulus for the debouncer.
REQ-009 The block SHALL have port busy, output, 1 bit, registered: high while in BOUNCE or SETTLE.
REQ-010 The block SHALL have port settled, output, 1 bit, registered: one-cycle pulse when a transition is complete.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BOUNCE and SETTLE.
REQ-012 In IDLE, when level_in != noisy at a clock edge, the block SHALL, at that edge:
- latch target = level_in;
- invert noisy (first toggle);
- load the toggle counter with BOUNCE_COUNT-1;
- load the interval counter;
- enter BOUNCE.
REQ-013 In BOUNCE, the interval counter SHALL decrement every cycle; when it reaches 0 and the toggle counter is nonzero, noisy SHALL invert, the toggle counter SHALL decrement and the interval counter SHALL reload.
REQ-014 In BOUNCE, when the interval counter reaches 0 and the toggle counter is 0, noisy SHALL be driven to target (overriding parity), the settle counter SHALL load SETTLE_CYCLES-1, and the FSM SHALL enter SETTLE.
REQ-015 In SETTLE, noisy SHALL hold target; when the settle counter reaches 0, settled SHALL pulse high for exactly one cycle and the FSM SHALL return to IDLE.
REQ-016 Changes on level_in during BOUNCE or SETTLE SHALL be ignored; on return to IDLE, a mismatch with noisy SHALL start a new burst on the next edge.
REQ-017 With BOUNCE_COUNT=1, the block SHALL make the single toggle, wait one interval, confirm target, and then settle.
REQ-018 busy SHALL go high on the same edge that performs the first toggle and SHALL go low on the edge that raises settled.
REQ-019 All counters SHALL be 16 bits wide (toggle counter 8 bits) and SHALL never wrap: reloads occur only at 0.

Reset
REQ-020 While reset_n is low, the block SHALL force: state=IDLE, noisy=0, busy=0, settled=0, target=0, all counters 0, LFSR=LFSR_SEED.
REQ-021 Reset asserted mid-burst SHALL abort the burst immediately, with no settled pulse.
REQ-022 After release, if level_in=1, a burst SHALL start on the first clock edge.

Configuration
REQ-023 When macro BOUNCE_RANDOM_EN is defined, the interval reload value SHALL be 1 + (lfsr[7:0] mod TOGGLE_INTERVAL).
- lfsr is a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle while reset_n is high.
REQ-024 When BOUNCE_RANDOM_EN is undefined, the interval reload SHALL be TOGGLE_INTERVAL and no LFSR logic SHALL be synthesised.

Structure
REQ-025 Package bounce_gen_pkg SHALL hold:
- the state enum (IDLE, BOUNCE, SETTLE);
- the LFSR tap mask constant;
- the default parameter constants.
REQ-026 The LFSR SHALL be a separate sub-module lfsr16 (clk, reset_n, seed, value), instantiated only under BOUNCE_RANDOM_EN.

Verification
REQ-027 The bench SHALL cover all of the following directed scenarios (fixed mode unless stated):
- Reset: hold reset_n low 5 cycles with level_in=0 -> noisy=0, busy=0, settled=0 throughout and after release.
- Nominal (BOUNCE_COUNT=3, TOGGLE_INTERVAL=4, SETTLE_CYCLES=6): level_in 0->1 at edge N -> noisy=1 at N, 0 at N+4, 1 at N+8, confirmed 1 at N+12, settled pulse at N+18, busy high N..N+17.
- Falling transition, same parameters, starting from settled 1 -> mirror sequence ending noisy=0, one settled pulse.
- level_in toggled 1->0->1 during BOUNCE -> burst unaffected; after settled, noisy=1 equals level_in, so no new burst and busy stays 0.
- Reset asserted at N+5 of the nominal case -> noisy=0 and busy=0 immediately; no settled pulse.
- BOUNCE_RANDOM_EN defined, TOGGLE_INTERVAL=8 -> every toggle spacing lies in 1..8; 20 bursts end with noisy=target and one settled pulse each.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// The LFSR tap mask is only consumed when BOUNCE_RANDOM_EN is defined.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } bounce_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    localparam int unsigned DEF_BOUNCE_COUNT    = 7;
    localparam int unsigned DEF_TOGGLE_INTERVAL = 50;
    localparam int unsigned DEF_SETTLE_CYCLES   = 200;
    localparam logic [15:0] DEF_LFSR_SEED       = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advances every cycle out of reset and reloads the seed in reset.
module lfsr16
    import bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed;
        end else begin
            value <= {value[14:0], ^(value & LFSR_TAP_MASK)};
        end
    end

endmodule

// File: rtl/bounce_generator.sv
// Emulates a bouncing mechanical contact: a burst of chatter toggles, then a settled level.
// Define BOUNCE_RANDOM_EN for LFSR-randomised toggle spacing instead of a fixed interval.
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_COUNT    = DEF_BOUNCE_COUNT,
    parameter int unsigned TOGGLE_INTERVAL = DEF_TOGGLE_INTERVAL,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter logic [15:0] LFSR_SEED       = DEF_LFSR_SEED
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level_in,
    output logic noisy,
    output logic busy,
    output logic settled
);

    localparam logic [7:0]  TOGGLE_LOAD = 8'(BOUNCE_COUNT - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    if (BOUNCE_COUNT == 0 || BOUNCE_COUNT > 255) begin : g_bad_bounce_count
        $error("bounce_generator: BOUNCE_COUNT must be 1..255");
    end
    if (TOGGLE_INTERVAL == 0 || TOGGLE_INTERVAL > 65535) begin : g_bad_toggle_interval
        $error("bounce_generator: TOGGLE_INTERVAL must be 1..65535");
    end
    if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 65535) begin : g_bad_settle_cycles
        $error("bounce_generator: SETTLE_CYCLES must be 1..65535");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_lfsr_seed
        $error("bounce_generator: LFSR_SEED must be nonzero");
    end

    bounce_state_e state;
    logic          target;
    logic [7:0]    toggle_cnt;
    logic [15:0]   interval_cnt;
    logic [15:0]   settle_cnt;
    logic [15:0]   interval_load;

    // Counter holds spacing-1 because the toggle fires on the edge that sees zero.
`ifdef BOUNCE_RANDOM_EN
    logic [15:0] lfsr_value;

    lfsr16 u_lfsr16 (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .value   (lfsr_value)
    );

    assign interval_load = 16'(32'(lfsr_value[7:0]) % TOGGLE_INTERVAL);
`else
    assign interval_load = 16'(TOGGLE_INTERVAL - 1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            noisy        <= 1'b0;
            busy         <= 1'b0;
            settled      <= 1'b0;
            target       <= 1'b0;
            toggle_cnt   <= 8'd0;
            interval_cnt <= 16'd0;
            settle_cnt   <= 16'd0;
        end else begin
            settled <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (level_in != noisy) begin
                        target       <= level_in;
                        noisy        <= ~noisy;
                        toggle_cnt   <= TOGGLE_LOAD;
                        interval_cnt <= interval_load;
                        busy         <= 1'b1;
                        state        <= BOUNCE;
                    end
                end
                BOUNCE: begin
                    if (interval_cnt != 16'd0) begin
                        interval_cnt <= interval_cnt - 16'd1;
                    end else if (toggle_cnt != 8'd0) begin
                        noisy        <= ~noisy;
                        toggle_cnt   <= toggle_cnt - 8'd1;
                        interval_cnt <= interval_load;
                    end else begin
                        // Final level is forced regardless of how many toggles preceded it.
                        noisy      <= target;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    noisy <= target;
                    if (settle_cnt != 16'd0) begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end else begin
                        settled <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
